// File: rtl/hnf_txreq_arb_if.sv
`default_nettype none
// ============================================================================
// hnf_txreq_arb_if : requester-side handshake and CHI TXREQ link signals
// Revision: 1.0
// ============================================================================
interface hnf_txreq_arb_if #(
  parameter int NUM_REQ = 3,
  parameter int FLIT_W  = 32
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][FLIT_W-1:0] req_flit;
  logic [NUM_REQ-1:0]             req_ready;
  logic [FLIT_W-1:0]              TXREQFLIT;
  logic                           TXREQFLITV;
  logic                           TXREQFLITPEND;
  logic                           TXREQLCRDV;

  modport master (
    input  req_valid, req_flit, TXREQLCRDV,
    output req_ready, TXREQFLIT, TXREQFLITV, TXREQFLITPEND
  );

  modport slave (
    output req_valid, req_flit, TXREQLCRDV,
    input  req_ready, TXREQFLIT, TXREQFLITV, TXREQFLITPEND
  );
endinterface
`default_nettype wire

// File: rtl/hnf_txreq_arb.sv
`default_nettype none
// ============================================================================
// hnf_txreq_arb : round-robin TXREQ scheduler with L-credit tracking/return
// Revision: 1.0
// ============================================================================
module hnf_txreq_arb #(
  parameter int NUM_REQ = 3,
  parameter int MAX_CRD = 15,
  parameter int FLIT_W  = 32,
  localparam int CNT_W  = $clog2(MAX_CRD + 1)
) (
  input  wire logic             clock,
  input  wire logic             reset,
  hnf_txreq_arb_if.master       txreq,
  input  wire logic             lnk_deact_req,
  output logic                  lnk_deact_done,
  output logic [CNT_W-1:0]      crd_cnt,
  output logic                  crd_overflow
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_STOP  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     crd_cnt_q, crd_cnt_d;
  logic                 crd_ovf_q, crd_ovf_d;
  logic [FLIT_W-1:0]    flit_q, flit_d;
  logic                 flitv_q, flitv_d;

  logic [NUM_REQ-1:0]   grant;
  logic [2*NUM_REQ-1:0] rot_valid;
  logic                 crd_avail;
  logic                 found;
  logic                 send;
  int                   off;
  int                   sel;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    crd_cnt_d = crd_cnt_q;
    crd_ovf_d = crd_ovf_q;
    flit_d    = flit_q;
    flitv_d   = 1'b0;
    grant     = '0;
    found     = 1'b0;
    send      = 1'b0;
    off       = 0;
    sel       = 0;

    // A credit arriving this cycle may be spent this cycle (bypass)
    crd_avail = (crd_cnt_q != '0) | txreq.TXREQLCRDV;

    // Doubled valid vector rotated so bit 0 is the requester at rr_ptr
    rot_valid = {txreq.req_valid, txreq.req_valid} >> rr_ptr_q;

    if (state_q == ST_RUN && !lnk_deact_req && crd_avail) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && rot_valid[i]) begin
          found = 1'b1;
          off   = i;
        end
      end
    end

    if (found) begin
      sel = int'(rr_ptr_q) + off;
      if (sel >= NUM_REQ) sel = sel - NUM_REQ;
      grant    = NUM_REQ'(1) << sel;
      rr_ptr_d = PTR_W'((sel + 1 >= NUM_REQ) ? 0 : sel + 1);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) flit_d = txreq.req_flit[i];
      end
      flitv_d = 1'b1;
      send    = 1'b1;
    end else if (state_q == ST_DRAIN && crd_avail) begin
      // ReqLCrdReturn: every field zero
      flit_d  = '0;
      flitv_d = 1'b1;
      send    = 1'b1;
    end

    if (txreq.TXREQLCRDV && !send) begin
      if (crd_cnt_q == CNT_W'(MAX_CRD)) crd_ovf_d = 1'b1;
      else                              crd_cnt_d = crd_cnt_q + CNT_W'(1);
    end else if (!txreq.TXREQLCRDV && send) begin
      crd_cnt_d = crd_cnt_q - CNT_W'(1);
    end

    case (state_q)
      ST_RUN: begin
        if (lnk_deact_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (crd_cnt_q == '0 && !txreq.TXREQLCRDV) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (!lnk_deact_req)         state_d = ST_RUN;
        else if (crd_cnt_q != '0)   state_d = ST_DRAIN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      rr_ptr_q  <= '0;
      crd_cnt_q <= '0;
      crd_ovf_q <= 1'b0;
      flit_q    <= '0;
      flitv_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      crd_cnt_q <= crd_cnt_d;
      crd_ovf_q <= crd_ovf_d;
      flit_q    <= flit_d;
      flitv_q   <= flitv_d;
    end
  end

  assign txreq.req_ready     = grant;
  assign txreq.TXREQFLIT     = flit_q;
  assign txreq.TXREQFLITV    = flitv_q;
  assign txreq.TXREQFLITPEND = (state_q != ST_STOP);
  assign lnk_deact_done      = (state_q == ST_STOP) && (crd_cnt_q == '0);
  assign crd_cnt             = crd_cnt_q;
  assign crd_overflow        = crd_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_hnf_txreq_arb.sv
`default_nettype none
// ============================================================================
// tb_hnf_txreq_arb : randomized scoreboard bench with a credit/arbitration model
// Revision: 1.0
// ============================================================================
module tb_hnf_txreq_arb;

  localparam int N      = 3;
  localparam int MAXC   = 15;
  localparam int FW     = 32;
  localparam int M_RUN  = 0;
  localparam int M_DRN  = 1;
  localparam int M_STOP = 2;

  logic       clock;
  logic       reset;
  logic       lnk_deact_req;
  logic       lnk_deact_done;
  logic [3:0] crd_cnt;
  logic       crd_overflow;

  hnf_txreq_arb_if #(.NUM_REQ(N), .FLIT_W(FW)) bus ();

  hnf_txreq_arb #(.NUM_REQ(N), .MAX_CRD(MAXC), .FLIT_W(FW)) dut (
    .clock          (clock),
    .reset          (reset),
    .txreq          (bus.master),
    .lnk_deact_req  (lnk_deact_req),
    .lnk_deact_done (lnk_deact_done),
    .crd_cnt        (crd_cnt),
    .crd_overflow   (crd_overflow)
  );

  typedef struct {
    int              cyc;
    logic [FW-1:0]   flit;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;

  // Reference model state
  int   m_mode, m_cnt, m_ptr;
  bit   m_ovf;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RUN;
    m_cnt  = 0;
    m_ptr  = 0;
    m_ovf  = 1'b0;
    sb.delete();
  endtask

  // One clock of stimulus: check registered outputs, drive, predict
  task automatic step(input logic [N-1:0] v, input logic crd, input logic deact);
    int            g;
    bit            avail, snd;
    logic [N-1:0]  exp_rdy;
    exp_t          e;
    @(negedge clock);
    chk("crd_cnt", crd_cnt, m_cnt);
    chk("crd_overflow", crd_overflow, m_ovf);
    chk("lnk_deact_done", lnk_deact_done, (m_mode == M_STOP && m_cnt == 0));
    chk("flitpend", bus.TXREQFLITPEND, (m_mode != M_STOP));
    bus.req_valid = v;
    for (int i = 0; i < N; i++) bus.req_flit[i] = $urandom;
    bus.TXREQLCRDV = crd;
    lnk_deact_req  = deact;
    #1;
    avail = (m_cnt > 0) || crd;
    g = -1;
    if (m_mode == M_RUN && !deact && avail) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", bus.req_ready, exp_rdy);
    snd = (g >= 0) || (m_mode == M_DRN && avail);
    if (snd) begin
      e.cyc  = cyc + 1;
      e.flit = (g >= 0) ? bus.req_flit[g] : '0;
      sb.push_back(e);
    end
    if (g >= 0) m_ptr = (g + 1) % N;
    case (m_mode)
      M_RUN:  if (deact) m_mode = M_DRN;
      M_DRN:  if (m_cnt == 0 && !crd) m_mode = M_STOP;
      default: begin
        if (!deact)          m_mode = M_RUN;
        else if (m_cnt != 0) m_mode = M_DRN;
      end
    endcase
    if (crd && !snd) begin
      if (m_cnt == MAXC) m_ovf = 1'b1;
      else               m_cnt++;
    end else if (!crd && snd) begin
      m_cnt--;
    end
  endtask

  // Monitor: every presented flit must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (reset === 1'b1) begin
        if (bus.TXREQFLITV === 1'b1) begin
          if (sb.size() == 0) begin
            chk("flit_unexpected", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("flit_cycle", cyc, e.cyc);
            chk("flit_data", bus.TXREQFLIT, e.flit);
          end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front();
          chk("flit_missing", 0, 1);
        end
      end
    end
  end

  task automatic check_reset_values();
    chk("rst_crd_cnt", crd_cnt, 0);
    chk("rst_flitv", bus.TXREQFLITV, 0);
    chk("rst_flit", bus.TXREQFLIT, 0);
    chk("rst_overflow", crd_overflow, 0);
    chk("rst_done", lnk_deact_done, 0);
    chk("rst_pend", bus.TXREQFLITPEND, 1);
  endtask

  initial begin
    logic deact_lvl;
    reset          = 1'b0;
    lnk_deact_req  = 1'b0;
    bus.req_valid  = '0;
    bus.req_flit   = '0;
    bus.TXREQLCRDV = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_reset_values();
    reset = 1'b1;

    // Three credits, requester 0 wants five flits
    repeat (3) step(3'b001, 1'b0, 1'b0);
    repeat (3) step(3'b000, 1'b1, 1'b0);
    repeat (5) step(3'b001, 1'b0, 1'b0);
    step(3'b001, 1'b1, 1'b0);

    // Fifteen credits, all requesters streaming
    repeat (15) step(3'b000, 1'b1, 1'b0);
    repeat (16) step(3'b111, 1'b0, 1'b0);

    // Simultaneous receive/send at four credits
    repeat (4) step(3'b000, 1'b1, 1'b0);
    step(3'b010, 1'b1, 1'b0);
    step(3'b000, 1'b0, 1'b0);
    chk("cnt_hold_4", crd_cnt, 4);

    // Drain five credits plus one arriving mid-drain
    step(3'b000, 1'b1, 1'b0);
    step(3'b111, 1'b0, 1'b1);
    step(3'b111, 1'b0, 1'b1);
    step(3'b111, 1'b1, 1'b1);
    repeat (8) step(3'b111, 1'b0, 1'b1);
    chk("drain_done", lnk_deact_done, 1);
    chk("drain_pend", bus.TXREQFLITPEND, 0);
    step(3'b001, 1'b0, 1'b0);
    step(3'b001, 1'b0, 1'b0);

    // Overflow: sixteen credits with no sends
    repeat (16) step(3'b000, 1'b1, 1'b0);
    step(3'b000, 1'b0, 1'b0);
    chk("ovf_cnt", crd_cnt, 15);
    chk("ovf_set", crd_overflow, 1);
    repeat (2) step(3'b000, 1'b0, 1'b0);
    chk("ovf_sticky", crd_overflow, 1);

    // Asynchronous reset in the middle of a drain holding three credits
    repeat (12) step(3'b100, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b1);
    #2;
    reset         = 1'b0;
    lnk_deact_req = 1'b0;
    sb.delete();
    #1;
    check_reset_values();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();

    // Only requester 2 valid with pointer at 0, then wrap check
    step(3'b100, 1'b1, 1'b0);
    step(3'b101, 1'b1, 1'b0);
    step(3'b111, 1'b1, 1'b0);

    // Randomized traffic with occasional link deactivation
    deact_lvl = 1'b0;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 99) < 3) deact_lvl = ~deact_lvl;
      step(N'($urandom_range(0, 7)), ($urandom_range(0, 99) < 40), deact_lvl);
    end

    repeat (3) step(3'b000, 1'b0, 1'b0);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hnf_txreq_arb.md
# hnf_txreq_arb

HN-F TXREQ channel scheduler. It shares the single outbound CHI TXREQ link between NUM_REQ internal requesters, such as the SLC ReadNoSnp path and future writeback/retry paths, using round-robin arbitration. It tracks link-layer L-credits granted by the downstream node and returns every held credit with ReqLCrdReturn link flits when the link is deactivated. It sits between the slice pipeline output stages and the CHI TXREQ pins.

## Interface
Parameters:
- NUM_REQ, default 3: number of internal requesters; index 0 has priority after reset.
- MAX_CRD, default 15: maximum L-credits held (CHI limit); the counter is $clog2(MAX_CRD+1) bits wide.

Ports:
- clock  in  1: single clock; all state updates on the rising edge.
- reset  in  1: asynchronous, active-low reset.
- req_valid  in  NUM_REQ: per-requester flit valid.
- req_flit  in  NUM_REQ x reqflit_t: per-requester request flit.
- req_ready  out  NUM_REQ: one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- TXREQFLIT  out  reqflit_t: outbound flit, registered.
- TXREQFLITV  out  1: outbound flit valid, registered, one cycle per flit.
- TXREQFLITPEND  out  1: flit-pending indication.
- TXREQLCRDV  in  1: one L-credit granted per cycle high.
- lnk_deact_req  in  1: level request to quiesce the link and return credits.
- lnk_deact_done  out  1: link stopped, zero credits held.
- crd_cnt  out  $clog2(MAX_CRD+1): current credit count.
- crd_overflow  out  1: sticky error; a credit was received while crd_cnt == MAX_CRD.

## Operation
States:
- RUN: grant requesters.
- DRAIN: no requester grants; send ReqLCrdReturn flits.
- STOP: idle, link quiesced.

Arbitration (RUN only):
- Eligible when crd_cnt > 0, or when TXREQLCRDV is high in the same cycle. Credit bypass is allowed.
- Grant goes to the first req_valid found scanning from rr_ptr upward, wrapping modulo NUM_REQ.
- req_ready is combinational. At most one bit is set, and only for a requester with req_valid high.
- On a transfer from requester i, rr_ptr becomes (i+1) mod NUM_REQ. rr_ptr does not change when nothing transfers.

Credit counter, per cycle:
- Change = +TXREQLCRDV − (flit sent this cycle: a requester transfer or a return flit).
- Simultaneous receive and send leaves the count unchanged.
- A receive at MAX_CRD with no send keeps the count at MAX_CRD and sets crd_overflow.
- crd_overflow clears only on reset.
- The count never underflows, because a send requires an available credit.

DRAIN:
- Each cycle with an available credit, load TXREQFLIT with all fields zero (Opcode 0x00 = ReqLCrdReturn), pulse TXREQFLITV, and decrement.
- Credits that arrive during DRAIN are also returned.

Transitions:
- RUN→DRAIN: lnk_deact_req high. The grant stops in the same cycle the request is sampled high, so no transfer occurs that cycle.
- DRAIN→STOP: crd_cnt == 0 and TXREQLCRDV low.
- STOP→RUN: lnk_deact_req low.
- DRAIN with lnk_deact_req deasserted: stays in DRAIN until the drain completes, then goes STOP→RUN.
- Credits received in STOP are counted, and crd_cnt becomes nonzero. lnk_deact_done is low whenever crd_cnt ≠ 0. If the FSM is still in STOP with lnk_deact_req high, it re-enters DRAIN.

Output signals:
- lnk_deact_done = (state == STOP) & (crd_cnt == 0).
- TXREQFLITPEND = (state != STOP). It is held high for the whole of RUN and DRAIN, which satisfies the one-cycle-before-FLITV rule.

## Timing
- Reset (reset low, asynchronous) sets:
  - state = RUN, rr_ptr = 0, crd_cnt = 0
  - TXREQFLIT = 0, TXREQFLITV = 0
  - crd_overflow = 0, lnk_deact_done = 0
- TXREQFLITPEND is 1 after reset.
- Reset mid-DRAIN discards held credits. The downstream node is reset alongside this block.
- Latency: a transfer in cycle N gives TXREQFLITV = 1 with the same flit in cycle N+1. crd_cnt shows the decrement in N+1.
- Throughput: one flit per cycle while credits are available.
- A credit arriving in cycle N is usable for a grant in cycle N via bypass, and is visible in crd_cnt in N+1.
- TXREQFLITV is low in every cycle that follows a cycle with no send.
- All outputs except req_ready are registered or derived from registered state only.

## Test plan
- Reset, then 3 TXREQLCRDV pulses with requester 0 valid for 5 flits → exactly 3 transfers, FLITV one cycle after each, crd_cnt 3→0, requester 0 stalls with req_ready = 0 until another credit arrives.
- All 3 requesters continuously valid with 15 credits → grant order 0,1,2,0,1,2,…, 15 flits on consecutive cycles, payloads match source.
- Credit receive and flit send in the same cycle at crd_cnt = 4 → crd_cnt stays 4. Pulse 16 credits with no sends → crd_cnt = 15, crd_overflow = 1 and stays 1.
- crd_cnt = 5 with lnk_deact_req raised and a credit arriving during DRAIN → 6 ReqLCrdReturn flits (all-zero), no req_ready, then STOP with lnk_deact_done = 1 and TXREQFLITPEND = 0. Dropping lnk_deact_req → RUN next cycle.
- Asynchronous reset asserted mid-DRAIN with crd_cnt = 3 → outputs immediately at reset values. After release, state is RUN with crd_cnt = 0.
- Only requester 2 valid with rr_ptr = 0 → requester 2 granted, rr_ptr becomes 0. Wrap-around is correct.
